cpu_mem_responder: RTL

- Responder end of the cpu_6502 memory bus.
- Decodes every CPU access (mem_addr / mem_write_en / mem_read_en) onto internal 2 KB work RAM, PPU register window, APU/IO stub, or cartridge port, and returns read data.
- Contains the OAM DMA engine: a write to $4014 stalls the CPU via halt and copies one 256-byte page to PPU register $2004.

---
 rtl/cpu_mem_responder.sv | 95 +++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: cpu_6502 bus responder with RAM/PPU/IO/cart decode and OAM DMA engine
module cpu_mem_responder #(
  parameter int          RAM_AW       = 11,
  parameter logic [15:0] DMA_REG      = 16'h4014,
  parameter logic [2:0]  OAM_DATA_REG = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_wdata,
  input  logic        mem_write_en,
  input  logic        mem_read_en,
  output logic [7:0]  mem_rdata,
  output logic        halt,
  output logic [2:0]  ppu_addr,
  output logic [7:0]  ppu_wdata,
  output logic        ppu_we,
  output logic        ppu_re,
  input  logic [7:0]  ppu_rdata,
  output logic [15:0] cart_addr,
  output logic [7:0]  cart_wdata,
  output logic        cart_we,
  output logic        cart_re,
  input  logic [7:0]  cart_rdata
);
  typedef enum logic [1:0] {IDLE, DUMMY, RD, WR} state_t;
  typedef enum logic [2:0] {T_NONE, T_RAM, T_PPU, T_ZERO, T_CART} tag_t;
  state_t state;
  tag_t rd_tag, dma_src, cpu_tag;
  logic [7:0] page, idx, hold, ram_q, rd_data, dma_byte;
  logic [7:0] ram [2**RAM_AW];
  logic [15:0] dma_addr;
  logic [RAM_AW-1:0] ram_addr;
  logic is_ram, is_ppu, is_cart, cpu_wr, cpu_rd, dma_rd, dma_wr, dma_ram, dma_cart;
  assign is_ram   = mem_addr[15:13] == 3'b000;
  assign is_ppu   = mem_addr[15:13] == 3'b001;
  assign is_cart  = mem_addr >= 16'h4020;
  assign cpu_tag  = is_ram ? T_RAM : is_ppu ? T_PPU : is_cart ? T_CART : T_ZERO;
  // write wins over read; halt and reset mute the CPU side entirely
  assign cpu_wr   = rst & ~halt & mem_write_en;
  assign cpu_rd   = rst & ~halt & mem_read_en & ~mem_write_en;
  assign dma_rd   = state == RD;
  assign dma_wr   = state == WR;
  assign dma_addr = {page, idx};
  assign dma_ram  = page < 8'h20;
  assign dma_cart = page > 8'h40;
  assign ram_addr = dma_rd ? dma_addr[RAM_AW-1:0] : mem_addr[RAM_AW-1:0];
  assign rd_data  = rd_tag == T_RAM ? ram_q : rd_tag == T_PPU ? ppu_rdata :
                    rd_tag == T_CART ? cart_rdata : 8'h00;
  assign dma_byte = dma_src == T_RAM ? ram_q : dma_src == T_CART ? cart_rdata : 8'h00;
  assign mem_rdata  = rd_tag == T_NONE ? hold : rd_data;
  assign ppu_we     = (cpu_wr & is_ppu) | dma_wr;
  assign ppu_re     = cpu_rd & is_ppu;
  assign cart_we    = cpu_wr & is_cart;
  assign cart_re    = (cpu_rd & is_cart) | (dma_rd & dma_cart);
  assign ppu_addr   = !rst ? 3'd0 : dma_wr ? OAM_DATA_REG : mem_addr[2:0];
  assign ppu_wdata  = !rst ? 8'h00 : dma_wr ? dma_byte : mem_wdata;
  assign cart_addr  = !rst ? 16'h0000 : dma_rd ? dma_addr : mem_addr;
  assign cart_wdata = rst ? mem_wdata : 8'h00;
  always_ff @(posedge clk) begin
    if (cpu_wr && is_ram) ram[mem_addr[RAM_AW-1:0]] <= mem_wdata;
    ram_q <= ram[ram_addr];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      halt    <= 1'b0;
      idx     <= 8'h00;
      page    <= 8'h00;
      dma_src <= T_ZERO;
      rd_tag  <= T_NONE;
      hold    <= 8'h00;
    end else begin
      rd_tag <= cpu_rd ? cpu_tag : T_NONE;
      if (rd_tag != T_NONE) hold <= mem_rdata;
      case (state)
        IDLE: if (cpu_wr && mem_addr == DMA_REG) begin
          page  <= mem_wdata;
          state <= DUMMY;
          halt  <= 1'b1;
        end
        DUMMY: state <= RD;
        RD: begin
          dma_src <= dma_ram ? T_RAM : dma_cart ? T_CART : T_ZERO;
          state   <= WR;
        end
        default: begin
          idx   <= idx + 8'd1;
          state <= idx == 8'hFF ? IDLE : RD;
          halt  <= idx != 8'hFF;
        end
      endcase
    end
  end
endmodule
